// File: rtl/seg_scan4.sv
// Four-digit multiplexed driver for a common-anode 7-segment display.
// Values are staged on LOAD and applied only at the frame boundary (slot 3 -> 0).
module seg_scan4 #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] VALUE,
  input  logic [3:0]  DP,
  input  logic        LOAD,
  output logic        PENDING,
  output logic        FRAME,
  output logic [7:0]  SEG,
  output logic [3:0]  DIGIT
);

  localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {SLOT0, SLOT1, SLOT2, SLOT3} slot_e;

  logic [CW-1:0] cnt_q, cnt_d;
  slot_e         slot_q, slot_d;
  logic [15:0]   stage_val_q, stage_val_d, shown_val_q, shown_val_d;
  logic [3:0]    stage_dp_q, stage_dp_d, shown_dp_q, shown_dp_d;
  logic          pending_q, pending_d, frame_q, frame_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    digit_q, digit_d;
  logic          tick, boundary;

  // Digit k is blank when it and every higher nibble and DP bit are all zero.
  function automatic logic [7:0] decode(input logic [15:0] v, input logic [3:0] dp,
                                        input logic [1:0] k);
    logic [15:0] vs;
    logic [3:0]  ds;
    logic [6:0]  s;
    vs = v >> {k, 2'b00};
    ds = dp >> k;
    case (vs[3:0])
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    if (BLANK_LZ && (k != 2'd0) && (vs == 16'h0) && (ds == 4'h0))
      return 8'hFF;
    return {~ds[0], s};
  endfunction

  always_comb begin
    tick     = (cnt_q == CW'(REFRESH_DIV - 1));
    cnt_d    = tick ? '0 : cnt_q + CW'(1);
    slot_d   = slot_q;
    if (tick) begin
      case (slot_q)
        SLOT0:   slot_d = SLOT1;
        SLOT1:   slot_d = SLOT2;
        SLOT2:   slot_d = SLOT3;
        default: slot_d = SLOT0;
      endcase
    end
    boundary = tick && (slot_q == SLOT3);

    shown_val_d = shown_val_q;
    shown_dp_d  = shown_dp_q;
    if (boundary && pending_q) begin
      shown_val_d = stage_val_q;
      shown_dp_d  = stage_dp_q;
    end
    stage_val_d = LOAD ? VALUE : stage_val_q;
    stage_dp_d  = LOAD ? DP : stage_dp_q;
    // A LOAD on the boundary edge re-arms PENDING for the following frame.
    pending_d   = LOAD | (pending_q & ~boundary);
    frame_d     = boundary;

    // Outputs are computed from next state so they line up with cnt_q/slot_q.
    seg_d = decode(shown_val_d, shown_dp_d, slot_d);
    case (slot_d)
      SLOT0:   digit_d = 4'b1110;
      SLOT1:   digit_d = 4'b1101;
      SLOT2:   digit_d = 4'b1011;
      default: digit_d = 4'b0111;
    endcase
    if (cnt_d == '0) digit_d = 4'hF;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q       <= '0;
      slot_q      <= SLOT0;
      stage_val_q <= '0;
      stage_dp_q  <= '0;
      shown_val_q <= '0;
      shown_dp_q  <= '0;
      pending_q   <= 1'b0;
      frame_q     <= 1'b0;
      seg_q       <= '1;
      digit_q     <= '1;
    end else begin
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      stage_val_q <= stage_val_d;
      stage_dp_q  <= stage_dp_d;
      shown_val_q <= shown_val_d;
      shown_dp_q  <= shown_dp_d;
      pending_q   <= pending_d;
      frame_q     <= frame_d;
      seg_q       <= seg_d;
      digit_q     <= digit_d;
    end
  end

  assign PENDING = pending_q;
  assign FRAME   = frame_q;
  assign SEG     = seg_q;
  assign DIGIT   = digit_q;

endmodule

// File: tb/tb_seg_scan4.sv
// Bench for seg_scan4: two instances (leading-zero blanking on/off) share stimulus;
// per-cycle expected outputs are queued per frame and popped as the scan runs.
module tb_seg_scan4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] VALUE = '0;
  logic [3:0]  DP = '0;
  logic        LOAD = 1'b0;
  logic        PENDING, FRAME, PENDING_n, FRAME_n;
  logic [7:0]  SEG, SEG_n;
  logic [3:0]  DIGIT, DIGIT_n;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  int          ld_at = -1;
  logic [15:0] ld_val = '0;
  logic [3:0]  ld_dp = '0;

  typedef struct {
    bit         frame;
    logic [3:0] digit;
    logic [7:0] seg_b;
    logic [7:0] seg_n;
  } exp_t;
  exp_t q[$];

  localparam logic [7:0] SEG_TBL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_scan4 #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_b (
    .CLK(CLK), .RST(RST), .VALUE(VALUE), .DP(DP), .LOAD(LOAD),
    .PENDING(PENDING), .FRAME(FRAME), .SEG(SEG), .DIGIT(DIGIT));

  seg_scan4 #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_n (
    .CLK(CLK), .RST(RST), .VALUE(VALUE), .DP(DP), .LOAD(LOAD),
    .PENDING(PENDING_n), .FRAME(FRAME_n), .SEG(SEG_n), .DIGIT(DIGIT_n));

  always #5 CLK = ~CLK;

  function automatic logic [7:0] exp_seg(input logic [15:0] v, input logic [3:0] dp,
                                         input int k, input bit blz);
    logic [3:0] nib;
    bit lead;
    nib  = v[4*k +: 4];
    lead = (k != 0);
    for (int j = k; j < 4; j++)
      if (v[4*j +: 4] != 4'h0 || dp[j]) lead = 1'b0;
    if (blz && lead) return 8'hFF;
    return dp[k] ? (SEG_TBL[nib] & 8'h7F) : SEG_TBL[nib];
  endfunction

  // Offsets 1..15 of a frame showing (v,dp); offset 16 is the next frame's first cycle.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] dp,
                            input logic [15:0] nv, input logic [3:0] ndp);
    exp_t e;
    for (int k = 1; k <= 16; k++) begin
      int slot, cnt;
      slot = (k < 16) ? k / 4 : 0;
      cnt  = k % 4;
      e.frame = (k == 16);
      e.digit = (cnt == 0) ? 4'hF : ~(4'b0001 << slot);
      e.seg_b = (k < 16) ? exp_seg(v, dp, slot, 1'b1) : exp_seg(nv, ndp, 0, 1'b1);
      e.seg_n = (k < 16) ? exp_seg(v, dp, slot, 1'b0) : exp_seg(nv, ndp, 0, 1'b0);
      q.push_back(e);
    end
  endtask

  task automatic scan(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      n_checks++;
      if (q.size() == 0) begin
        $display("FAIL scan_queue: queue empty at step %0d", i);
      end else begin
        e = q.pop_front();
        if (FRAME !== e.frame || FRAME_n !== e.frame)
          $display("FAIL scan_frame t=%0t: got %b/%b want %b", $time, FRAME, FRAME_n, e.frame);
        else if (DIGIT !== e.digit || DIGIT_n !== e.digit)
          $display("FAIL scan_digit t=%0t: got %h/%h want %h", $time, DIGIT, DIGIT_n, e.digit);
        else if (SEG !== e.seg_b)
          $display("FAIL scan_seg_blank t=%0t: got %h want %h", $time, SEG, e.seg_b);
        else if (SEG_n !== e.seg_n)
          $display("FAIL scan_seg_noblank t=%0t: got %h want %h", $time, SEG_n, e.seg_n);
        else
          n_pass++;
      end
      LOAD = (i == ld_at);
      if (i == ld_at) begin
        VALUE = ld_val;
        DP    = ld_dp;
      end
    end
    ld_at = -1;
  endtask

  task automatic check_pending(input string name, input logic exp);
    n_checks++;
    if (PENDING !== exp || PENDING_n !== exp)
      $display("FAIL %s: PENDING got %b/%b want %b", name, PENDING, PENDING_n, exp);
    else
      n_pass++;
  endtask

  task automatic check_reset_state(input string name);
    n_checks++;
    if (SEG !== 8'hFF || DIGIT !== 4'hF || PENDING !== 1'b0 || FRAME !== 1'b0 ||
        SEG_n !== 8'hFF || DIGIT_n !== 4'hF)
      $display("FAIL %s: SEG=%h DIGIT=%h PENDING=%b FRAME=%b want FF F 0 0",
               name, SEG, DIGIT, PENDING, FRAME);
    else
      n_pass++;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset_state("reset_state");
    RST = 1'b0;
    push_frame(16'h0000, 4'h0, 16'h0000, 4'h0);
    scan(16);
    push_frame(16'h0000, 4'h0, 16'h0000, 4'h0);
    scan(16);
  endtask

  task automatic test_deferred_load;
    push_frame(16'h0000, 4'h0, 16'h12AF, 4'b0100);
    ld_at = 5; ld_val = 16'h12AF; ld_dp = 4'b0100;
    scan(10);
    check_pending("deferred_pending_set", 1'b1);
    scan(6);
    check_pending("deferred_pending_clr", 1'b0);
    push_frame(16'h12AF, 4'b0100, 16'h12AF, 4'b0100);
    scan(16);
  endtask

  task automatic test_back_to_back;
    push_frame(16'h12AF, 4'b0100, 16'h2222, 4'h0);
    ld_at = 2; ld_val = 16'h1111; ld_dp = 4'h0;
    scan(5);
    check_pending("b2b_pending_first", 1'b1);
    ld_at = 3; ld_val = 16'h2222; ld_dp = 4'h0;
    scan(11);
    check_pending("b2b_pending_clr", 1'b0);
    push_frame(16'h2222, 4'h0, 16'h2222, 4'h0);
    scan(16);
    check_pending("b2b_pending_stays_clr", 1'b0);
  endtask

  task automatic test_load_on_boundary;
    push_frame(16'h2222, 4'h0, 16'h2222, 4'h0);
    ld_at = 14; ld_val = 16'h0005; ld_dp = 4'h0;
    scan(16);
    check_pending("boundary_load_pending", 1'b1);
    push_frame(16'h2222, 4'h0, 16'h0005, 4'h0);
    scan(16);
    check_pending("boundary_load_applied", 1'b0);
  endtask

  task automatic test_leading_zeros;
    push_frame(16'h0005, 4'h0, 16'h0050, 4'h0);
    ld_at = 0; ld_val = 16'h0050; ld_dp = 4'h0;
    scan(16);
    push_frame(16'h0050, 4'h0, 16'h0000, 4'b1000);
    ld_at = 0; ld_val = 16'h0000; ld_dp = 4'b1000;
    scan(16);
    push_frame(16'h0000, 4'b1000, 16'h0000, 4'b1000);
    scan(16);
  endtask

  task automatic test_reset_mid_pending;
    push_frame(16'h0000, 4'b1000, 16'h0000, 4'b1000);
    ld_at = 2; ld_val = 16'hFFFF; ld_dp = 4'hF;
    scan(5);
    check_pending("midreset_pending_before", 1'b1);
    q.delete();
    RST = 1'b1;
    @(negedge CLK);
    check_reset_state("midreset_state");
    @(negedge CLK);
    check_reset_state("midreset_state_held");
    RST = 1'b0;
    push_frame(16'h0000, 4'h0, 16'h0000, 4'h0);
    scan(16);
    check_pending("midreset_pending_after", 1'b0);
  endtask

  initial begin
    test_reset;
    test_deferred_load;
    test_back_to_back;
    test_load_on_boundary;
    test_leading_zeros;
    test_reset_mid_pending;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan4.md
Name: seg_scan4

Overview:
- Four-digit time-multiplexed driver for the board's common-anode 7-segment display.
- Replaces the fixed single-digit enable with a rotating digit scan.
- Latches a 16-bit hex value plus decimal points from upstream logic, then drives SEG and DIGIT directly.
- New values are applied only on frame boundaries, so the display never shows a half-updated value.

Parameters:
- REFRESH_DIV, 50000: CLK cycles per digit slot (≥2). Tests use 4.
- BLANK_LZ, 1: 1 = blank leading zero digits; 0 = always show all four digits.

Ports:
- CLK, in, 1: system clock.
- RST, in, 1: reset.
- VALUE, in, 16: hex value; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- DP, in, 4: decimal-point enables; DP[k] belongs to digit k.
- LOAD, in, 1: one-cycle strobe; captures VALUE and DP.
- PENDING, out, 1: a captured value is waiting for the next frame boundary.
- FRAME, out, 1: one-cycle pulse when the scan wraps to digit 0.
- SEG, out, 8: active-low segments; [7]=dp, [6:0]=g,f,e,d,c,b,a.
- DIGIT, out, 4: active-low digit enables; bit k drives digit k.

Behaviour:
- Clocking and reset:
  - One clock (CLK).
  - RST is synchronous and active-high.
  - All outputs are registered.
- Reset values:
  - cnt=0, slot=0, staging=0, shown=0 (value and DP).
  - PENDING=0, FRAME=0, SEG=8'hFF, DIGIT=4'hF.
  - RST asserted mid-frame or mid-pending aborts immediately; the staged value is discarded.
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick = (cnt == REFRESH_DIV-1).
- Scan:
  - On tick, slot advances 0→1→2→3→0.
  - DIGIT for slot 0/1/2/3 is 4'b1110 / 4'b1101 / 4'b1011 / 4'b0111.
- Ghost guard:
  - While cnt==0, DIGIT=4'hF and SEG already holds the pattern for the new slot.
  - The digit is therefore lit for REFRESH_DIV-1 cycles per slot.
  - The first cycle after reset release is blanked.
- Frame boundary:
  - Occurs on the tick where slot goes 3→0.
  - On that edge, staging is copied to shown, PENDING is cleared, and FRAME=1 for exactly one cycle.
  - If PENDING=0 at the boundary, shown is unchanged; FRAME still pulses.
- Load handshake:
  - LOAD=1 captures VALUE and DP into staging and sets PENDING=1.
  - LOAD while PENDING=1: staging is overwritten (latest wins); PENDING stays 1.
  - LOAD on the same cycle as a frame boundary: the old staging is applied; the new value goes to staging and PENDING stays 1; it is applied at the next boundary.
  - LOAD held high captures every cycle; no error condition exists.
- Decode (nibble → SEG[6:0], active-low) with DP off:
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8
  - 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E
  - DP[k]=1 clears SEG[7].
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k (k=3,2,1) shows SEG=8'hFF when its nibble and all higher nibbles are 0 and its DP bit is 0.
  - Digit 0 is never blanked.
  - A set DP on a blanked position prevents blanking of that position and all lower positions.
- SEG and DIGIT are always derived from shown, never from staging or VALUE.

Test Plan:
1. Reset and scan (REFRESH_DIV=4, no load):
   - First cycle after RST drop: DIGIT=F.
   - Then DIGIT=E for 3 cycles with SEG=C0.
   - Digits 1–3 have SEG=FF while their DIGIT bit is low.
   - FRAME pulses every 16 cycles.
2. Deferred load:
   - LOAD VALUE=16'h12AF, DP=4'b0100 mid slot 1.
   - PENDING=1 until the 3→0 tick; display unchanged until then.
   - Next frame shows digit 0=8E, 1=88, 2=24 (A4 with dp), 3=F9.
3. Back-to-back loads:
   - LOAD 16'h1111 then LOAD 16'h2222 within the same frame.
   - Only 2222 is displayed; PENDING clears once.
4. LOAD coincident with boundary:
   - LOAD 16'h0005 on the 3→0 tick while PENDING=0.
   - Display unchanged for that frame; PENDING=1; 0005 shown after the next FRAME.
5. Leading zeros:
   - 16'h0050 shows FF, FF, 92, C0 (digits 3..0).
   - 16'h0000 with DP=4'b1000 shows 40, C0, C0, C0.
   - Repeat with BLANK_LZ=0: 16'h0050 shows C0, C0, 92, C0.
6. Reset mid-pending:
   - LOAD 16'hFFFF, then RST before the boundary.
   - Outputs return to reset values; after release digit 0 shows C0 and PENDING=0.
